// File: rtl/updw_pkg.sv
// Shared constants for the up/down counter direction controller.
package updw_pkg;

    // Count direction encoding seen by updw_cnt.
    localparam logic MODE_UP = 1'b1;
    localparam logic MODE_DN = 1'b0;

    // Debounce FSM encoding; bit 1 set means the accepted level is high.
    localparam logic [1:0] S_LO      = 2'd0;
    localparam logic [1:0] S_WAIT_HI = 2'd1;
    localparam logic [1:0] S_HI      = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

endpackage : updw_pkg

// File: rtl/updw_mode_ctrl_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce FSM and a
// registered one-cycle pulse on every accepted low-to-high transition.
module btn_debounce
    import updw_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic             btn_s;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_q;
    logic             rise_d;
    logic             level_q;
    logic             level_d;

    // Shift the raw button into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[0], i_btn};
    end

    assign btn_s = sync_q[1];

    // Debounce next-state: a level change must hold for DB_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        case (state_q)
            S_LO: begin
                if (btn_s) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!btn_s) begin
                    state_d = S_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HI;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (!btn_s) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (btn_s) begin
                    state_d = S_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
        level_d = (state_d == S_HI) || (state_d == S_WAIT_LO);
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q  <= 2'b00;
            state_q <= S_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule : btn_debounce

// File: rtl/updw_mode_ctrl.sv
// Direction controller for updw_cnt: manual toggle on debounced presses,
// or automatic ping-pong between 0 and UPBND.
module updw_mode_ctrl
    import updw_pkg::*;
#(
    parameter int unsigned UPBND     = 11,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter logic        MODE_RST  = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_btn,
    input  logic                         i_auto,
    input  logic [$clog2(UPBND+1)-1:0]   i_cnt,
    output logic                         o_mode,
    output logic                         o_btn_pulse,
    output logic                         o_dir_chg
);

    localparam int unsigned CNT_W = $clog2(UPBND + 1);
    // Flip one value early: the counter lands on the bound with the new mode.
    localparam logic [CNT_W-1:0] CNT_TURN_DN = CNT_W'(UPBND - 1);
    localparam logic [CNT_W-1:0] CNT_TURN_UP = CNT_W'(1);

    logic btn_level;
    logic btn_rise;
    logic mode_q;
    logic mode_d;
    logic dir_chg_q;
    logic dir_chg_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_btn  (i_btn),
        .o_level(btn_level),
        .o_rise (btn_rise)
    );

    // Next direction: bounds rule in auto mode, accepted press in manual mode.
    always_comb begin
        mode_d = mode_q;
        if (i_auto) begin
            if ((mode_q == MODE_UP) && (i_cnt == CNT_TURN_DN)) begin
                mode_d = MODE_DN;
            end else if ((mode_q == MODE_DN) && (i_cnt == CNT_TURN_UP)) begin
                mode_d = MODE_UP;
            end
        end else if (btn_rise && btn_level) begin
            mode_d = ~mode_q;
        end
        dir_chg_d = (mode_d != mode_q);
    end

    // Mode and direction-change registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q    <= MODE_RST;
            dir_chg_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            dir_chg_q <= dir_chg_d;
        end
    end

    assign o_mode      = mode_q;
    assign o_btn_pulse = btn_rise;
    assign o_dir_chg   = dir_chg_q;

endmodule : updw_mode_ctrl
